// File: rtl/wb_pkg.sv
// Shared definitions for the writeback / retire stage.
package wb_pkg;

  // Architectural EFLAGS bit positions
  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  // Bit 1 of EFLAGS is architecturally always set
  localparam logic [31:0] EFLAGS_RESET = 32'h0000_0002;

  // Store datasize encodings
  localparam logic [1:0] DS_BYTE  = 2'd0;
  localparam logic [1:0] DS_WORD  = 2'd1;
  localparam logic [1:0] DS_DWORD = 2'd2;

  typedef enum logic {
    REP_IDLE   = 1'b0,
    REP_ACTIVE = 1'b1
  } rep_state_e;

  // Expand the compact {OF,DF,SF,ZF,AF,PF,CF} mask onto EFLAGS bit positions
  function automatic logic [31:0] flag_mask(input logic [6:0] m);
    logic [31:0] r;
    r          = '0;
    r[FLAG_CF] = m[0];
    r[FLAG_PF] = m[1];
    r[FLAG_AF] = m[2];
    r[FLAG_ZF] = m[3];
    r[FLAG_SF] = m[4];
    r[FLAG_DF] = m[5];
    r[FLAG_OF] = m[6];
    return r;
  endfunction

endpackage

// File: rtl/store_queue.sv
// Circular FIFO holding retired stores until the D-cache accepts them.
module store_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // Payload storage; no reset needed since entries are only read when valid
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/writeback_sq.sv
// Writeback / retire stage: GPR commit, EFLAGS merge, REPNE count tracking
// and a store queue draining to the D-cache.
module writeback_sq
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int SQ_DEPTH   = 4,
  parameter int NUM_GPR_WR = 3,
  parameter int DR_W       = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         WB_V,
  output logic                         WB_READY,
  input  logic [NUM_GPR_WR*DR_W-1:0]   WB_DR,
  input  logic [NUM_GPR_WR-1:0]        WB_LD_GPR,
  input  logic [NUM_GPR_WR*DATA_W-1:0] WB_DATA,
  input  logic                         WB_ST,
  input  logic [ADDR_W-1:0]            WB_ADDRESS,
  input  logic [DATA_W-1:0]            WB_ST_DATA,
  input  logic [1:0]                   WB_DATASIZE,
  input  logic [31:0]                  WB_FLAGS,
  input  logic                         WB_LD_FLAGS,
  input  logic [6:0]                   WB_FLAGS_AFFECTED,
  input  logic                         WB_REP_FIRST,
  input  logic                         WB_REP_STEP,
  input  logic [31:0]                  WB_COUNT,
  output logic [NUM_GPR_WR*DR_W-1:0]   Out_DR,
  output logic [NUM_GPR_WR*DATA_W-1:0] Out_DR_Data,
  output logic [NUM_GPR_WR-1:0]        Out_v_ld_gpr,
  output logic [31:0]                  Out_Flags,
  output logic [31:0]                  Out_Count,
  output logic                         Out_repne_term,
  output logic                         Out_Dcache_Valid,
  input  logic                         Dcache_Ready,
  output logic [ADDR_W-1:0]            Out_Dcache_Address,
  output logic [DATA_W-1:0]            Out_Dcache_Data,
  output logic [1:0]                   Out_Dcache_Size,
  output logic                         Out_sq_empty
);

  localparam int SQ_W = ADDR_W + DATA_W + 2;

  logic            retire;
  logic            sq_full, sq_empty, sq_push, sq_pop;
  logic [SQ_W-1:0] sq_head;

  logic [31:0] flags_q, flags_d, flags_wmask;
  logic [31:0] count_q, rep_base, rep_dec;
  rep_state_e  rep_state_q;
  logic        rep_step, rep_term;

  // Stall only on a store that cannot be queued; full comes from registers only
  assign WB_READY = !(WB_ST && sq_full);
  assign retire   = WB_V && WB_READY;

  assign Out_DR       = WB_DR;
  assign Out_DR_Data  = WB_DATA;
  assign Out_v_ld_gpr = {NUM_GPR_WR{retire}} & WB_LD_GPR;

  assign sq_push = retire && WB_ST;
  assign sq_pop  = Out_Dcache_Valid && Dcache_Ready;

  store_queue #(
    .DEPTH (SQ_DEPTH),
    .W     (SQ_W)
  ) u_store_queue (
    .clk     (CLK),
    .rst_n   (RST),
    .push_i  (sq_push),
    .din_i   ({WB_ADDRESS, WB_ST_DATA, WB_DATASIZE}),
    .pop_i   (sq_pop),
    .dout_o  (sq_head),
    .full_o  (sq_full),
    .empty_o (sq_empty)
  );

  assign Out_Dcache_Valid   = !sq_empty;
  assign Out_sq_empty       = sq_empty;
  assign Out_Dcache_Address = sq_head[SQ_W-1 -: ADDR_W];
  assign Out_Dcache_Data    = sq_head[DATA_W+1 -: DATA_W];
  assign Out_Dcache_Size    = sq_head[1:0];

  // Post-merge flags; the REPNE terminate decision uses the merged ZF
  always_comb begin
    flags_wmask = (retire && WB_LD_FLAGS) ? flag_mask(WB_FLAGS_AFFECTED) : '0;
    flags_d     = (flags_q & ~flags_wmask) | (WB_FLAGS & flags_wmask) | EFLAGS_RESET;
  end

  // Iteration step: a FIRST in the same uop loads WB_COUNT before decrementing
  always_comb begin
    rep_base = WB_REP_FIRST ? WB_COUNT : count_q;
    rep_dec  = (rep_base == '0) ? '0 : rep_base - 32'd1;
    rep_step = retire && WB_REP_STEP && (WB_REP_FIRST || rep_state_q == REP_ACTIVE);
    rep_term = rep_step && ((rep_dec == '0) || flags_d[FLAG_ZF]);
  end

  assign Out_repne_term = rep_term;
  assign Out_Count      = count_q;
  assign Out_Flags      = flags_q;

  // Architectural EFLAGS register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) flags_q <= EFLAGS_RESET;
    else      flags_q <= flags_d;
  end

  // REPNE sequencer: IDLE until FIRST, ACTIVE until a step terminates
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rep_state_q <= REP_IDLE;
      count_q     <= '0;
    end else if (rep_step) begin
      count_q     <= rep_dec;
      rep_state_q <= rep_term ? REP_IDLE : REP_ACTIVE;
    end else if (retire && WB_REP_FIRST) begin
      count_q     <= WB_COUNT;
      rep_state_q <= REP_ACTIVE;
    end
  end

endmodule

// File: tb/tb_writeback_sq.sv
// Randomised and directed bench for writeback_sq against a queue-based model.
module tb_writeback_sq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WB_V, WB_READY;
  logic [8:0]  WB_DR;
  logic [2:0]  WB_LD_GPR;
  logic [95:0] WB_DATA;
  logic        WB_ST;
  logic [31:0] WB_ADDRESS, WB_ST_DATA;
  logic [1:0]  WB_DATASIZE;
  logic [31:0] WB_FLAGS;
  logic        WB_LD_FLAGS;
  logic [6:0]  WB_FLAGS_AFFECTED;
  logic        WB_REP_FIRST, WB_REP_STEP;
  logic [31:0] WB_COUNT;
  logic [8:0]  Out_DR;
  logic [95:0] Out_DR_Data;
  logic [2:0]  Out_v_ld_gpr;
  logic [31:0] Out_Flags, Out_Count;
  logic        Out_repne_term, Out_Dcache_Valid, Dcache_Ready;
  logic [31:0] Out_Dcache_Address, Out_Dcache_Data;
  logic [1:0]  Out_Dcache_Size;
  logic        Out_sq_empty;

  writeback_sq dut (
    .CLK(CLK), .RST(RST), .WB_V(WB_V), .WB_READY(WB_READY), .WB_DR(WB_DR),
    .WB_LD_GPR(WB_LD_GPR), .WB_DATA(WB_DATA), .WB_ST(WB_ST), .WB_ADDRESS(WB_ADDRESS),
    .WB_ST_DATA(WB_ST_DATA), .WB_DATASIZE(WB_DATASIZE), .WB_FLAGS(WB_FLAGS),
    .WB_LD_FLAGS(WB_LD_FLAGS), .WB_FLAGS_AFFECTED(WB_FLAGS_AFFECTED),
    .WB_REP_FIRST(WB_REP_FIRST), .WB_REP_STEP(WB_REP_STEP), .WB_COUNT(WB_COUNT),
    .Out_DR(Out_DR), .Out_DR_Data(Out_DR_Data), .Out_v_ld_gpr(Out_v_ld_gpr),
    .Out_Flags(Out_Flags), .Out_Count(Out_Count), .Out_repne_term(Out_repne_term),
    .Out_Dcache_Valid(Out_Dcache_Valid), .Dcache_Ready(Dcache_Ready),
    .Out_Dcache_Address(Out_Dcache_Address), .Out_Dcache_Data(Out_Dcache_Data),
    .Out_Dcache_Size(Out_Dcache_Size), .Out_sq_empty(Out_sq_empty)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
  } st_t;

  // Reference state
  st_t         m_sq[$];
  logic [31:0] m_flags;
  logic [31:0] m_count;
  logic        m_active;
  int          fb[7] = '{0, 2, 4, 6, 7, 10, 11};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    WB_V = 0; WB_DR = '0; WB_LD_GPR = '0; WB_DATA = '0; WB_ST = 0;
    WB_ADDRESS = '0; WB_ST_DATA = '0; WB_DATASIZE = '0; WB_FLAGS = '0;
    WB_LD_FLAGS = 0; WB_FLAGS_AFFECTED = '0; WB_REP_FIRST = 0; WB_REP_STEP = 0;
    WB_COUNT = '0;
  endtask

  task automatic model_reset();
    m_sq.delete();
    m_flags  = 32'h2;
    m_count  = 0;
    m_active = 0;
  endtask

  // Check every output against the model for the current inputs, then clock once
  task automatic step();
    logic        rdy, ret, rstep, term;
    logic [31:0] msk, nflags, base, dec;
    st_t         e;
    #1;
    rdy = !(WB_ST && m_sq.size() == 4);
    ret = WB_V && rdy;
    msk = '0;
    if (ret && WB_LD_FLAGS)
      for (int i = 0; i < 7; i++) msk[fb[i]] = WB_FLAGS_AFFECTED[i];
    nflags = (m_flags & ~msk) | (WB_FLAGS & msk) | 32'h2;
    rstep  = ret && WB_REP_STEP && (WB_REP_FIRST || m_active);
    base   = WB_REP_FIRST ? WB_COUNT : m_count;
    dec    = (base == 0) ? 32'd0 : base - 32'd1;
    term   = rstep && (dec == 0 || nflags[6]);

    check_eq("ready", WB_READY, rdy);
    check_eq("v_ld_gpr", Out_v_ld_gpr, ret ? WB_LD_GPR : 3'b000);
    check_eq("dr", Out_DR, WB_DR);
    check_eq("dr_data", Out_DR_Data, WB_DATA);
    check_eq("flags", Out_Flags, m_flags);
    check_eq("count", Out_Count, m_count);
    check_eq("term", Out_repne_term, term);
    check_eq("dc_valid", Out_Dcache_Valid, m_sq.size() != 0);
    check_eq("sq_empty", Out_sq_empty, m_sq.size() == 0);
    if (m_sq.size() != 0) begin
      check_eq("dc_addr", Out_Dcache_Address, m_sq[0].a);
      check_eq("dc_data", Out_Dcache_Data, m_sq[0].d);
      check_eq("dc_size", Out_Dcache_Size, m_sq[0].s);
    end

    @(posedge CLK); #1;
    if (m_sq.size() != 0 && Dcache_Ready) e = m_sq.pop_front();
    if (ret && WB_ST) begin
      e.a = WB_ADDRESS; e.d = WB_ST_DATA; e.s = WB_DATASIZE;
      m_sq.push_back(e);
    end
    m_flags = nflags;
    if (rstep) begin
      m_count  = dec;
      m_active = !term;
    end else if (ret && WB_REP_FIRST) begin
      m_count  = WB_COUNT;
      m_active = 1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    WB_V = 1; WB_ST = 1; WB_ADDRESS = a; WB_ST_DATA = d; WB_DATASIZE = 2'd2;
    WB_LD_GPR = 3'b001; WB_DATA = {64'h0, d};
  endtask

  initial begin
    RST = 0; Dcache_Ready = 0;
    idle_inputs();
    model_reset();
    #12;
    check_eq("rst_flags", Out_Flags, 32'h2);
    check_eq("rst_valid", Out_Dcache_Valid, 1'b0);
    check_eq("rst_empty", Out_sq_empty, 1'b1);
    check_eq("rst_count", Out_Count, 32'h0);
    check_eq("rst_term", Out_repne_term, 1'b0);
    check_eq("rst_v_ld_gpr", Out_v_ld_gpr, 3'b000);
    @(posedge CLK); #1; RST = 1;

    // Same-cycle GPR commit
    WB_V = 1; WB_LD_GPR = 3'b101; WB_DATA = {64'h1111_2222_3333_4444, 32'hDEAD_BEEF};
    WB_DR = 9'o753;
    #1 check_eq("gpr_101", Out_v_ld_gpr, 3'b101);
    check_eq("gpr_data0", Out_DR_Data[31:0], 32'hDEAD_BEEF);
    step();
    check_eq("flags_untouched", Out_Flags, 32'h2);

    // ZF-only merge
    idle_inputs();
    WB_V = 1; WB_LD_FLAGS = 1; WB_FLAGS = 32'hFFFF_FFFF; WB_FLAGS_AFFECTED = 7'b0001000;
    step();
    check_eq("flags_zf", Out_Flags, 32'h0000_0042);

    // Fill the queue with the cache stalled, then a fifth store must stall
    idle_inputs(); Dcache_Ready = 0;
    for (int i = 0; i < 4; i++) begin
      store(32'hA0 + 32'(i), 32'h1000 + 32'(i));
      step();
    end
    store(32'hA4, 32'h1004);
    #1 check_eq("full_ready", WB_READY, 1'b0);
    check_eq("full_gpr_suppressed", Out_v_ld_gpr, 3'b000);
    step();
    idle_inputs(); Dcache_Ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("drain_order", Out_Dcache_Address, 32'hA0 + 32'(i));
      step();
    end
    check_eq("drained", Out_sq_empty, 1'b1);

    // Push and pop together with two entries queued
    Dcache_Ready = 0;
    store(32'hB0, 32'h2000); step();
    store(32'hB1, 32'h2001); step();
    Dcache_Ready = 1;
    store(32'hB2, 32'h2002); step();
    check_eq("pushpop_head", Out_Dcache_Address, 32'hB1);
    idle_inputs(); Dcache_Ready = 0;
    step();
    check_eq("pushpop_occ", m_sq.size(), 2);
    Dcache_Ready = 1; step(); step(); step();

    // Clear ZF, then REPNE count 3 with ZF=0
    idle_inputs();
    WB_V = 1; WB_LD_FLAGS = 1; WB_FLAGS = 32'h0; WB_FLAGS_AFFECTED = 7'b0001000;
    step();
    idle_inputs(); WB_V = 1; WB_REP_FIRST = 1; WB_COUNT = 3; step();
    check_eq("rep3_load", Out_Count, 32'd3);
    idle_inputs(); WB_V = 1; WB_REP_STEP = 1;
    step(); check_eq("rep3_c2", Out_Count, 32'd2);
    step(); check_eq("rep3_c1", Out_Count, 32'd1);
    #1 check_eq("rep3_term", Out_repne_term, 1'b1);
    step(); check_eq("rep3_c0", Out_Count, 32'd0);
    #1 check_eq("rep_idle_step", Out_repne_term, 1'b0);
    step();

    // REPNE count 5, ZF set on the second step
    idle_inputs(); WB_V = 1; WB_REP_FIRST = 1; WB_COUNT = 5; step();
    idle_inputs(); WB_V = 1; WB_REP_STEP = 1; step();
    WB_LD_FLAGS = 1; WB_FLAGS = 32'h40; WB_FLAGS_AFFECTED = 7'b0001000;
    #1 check_eq("rep5_zf_term", Out_repne_term, 1'b1);
    step(); check_eq("rep5_count", Out_Count, 32'd3);

    // FIRST+STEP with count 0
    idle_inputs(); WB_V = 1; WB_LD_FLAGS = 1; WB_FLAGS_AFFECTED = 7'b0001000; step();
    idle_inputs(); WB_V = 1; WB_REP_FIRST = 1; WB_REP_STEP = 1; WB_COUNT = 0;
    #1 check_eq("rep0_term", Out_repne_term, 1'b1);
    step(); check_eq("rep0_count", Out_Count, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      WB_V              = ($urandom_range(0, 3) != 0);
      WB_DR             = 9'($urandom);
      WB_LD_GPR         = 3'($urandom);
      WB_DATA           = {$urandom, $urandom, $urandom};
      WB_ST             = ($urandom_range(0, 2) == 0);
      WB_ADDRESS        = $urandom;
      WB_ST_DATA        = $urandom;
      WB_DATASIZE       = 2'($urandom_range(0, 2));
      WB_FLAGS          = $urandom;
      WB_LD_FLAGS       = ($urandom_range(0, 2) == 0);
      WB_FLAGS_AFFECTED = 7'($urandom);
      WB_REP_FIRST      = ($urandom_range(0, 7) == 0);
      WB_REP_STEP       = $urandom_range(0, 1) == 1;
      WB_COUNT          = $urandom_range(0, 6);
      Dcache_Ready      = ($urandom_range(0, 2) == 0);
      step();
    end

    // Reset while stores are pending
    idle_inputs(); Dcache_Ready = 0;
    store(32'hC0, 32'h3000); step();
    store(32'hC1, 32'h3001); step();
    idle_inputs();
    check_eq("pre_rst_valid", Out_Dcache_Valid, 1'b1);
    #2 RST = 0;
    #1 check_eq("midrst_valid", Out_Dcache_Valid, 1'b0);
    check_eq("midrst_empty", Out_sq_empty, 1'b1);
    check_eq("midrst_flags", Out_Flags, 32'h2);
    check_eq("midrst_count", Out_Count, 32'h0);
    model_reset();
    @(posedge CLK); #1; RST = 1; Dcache_Ready = 1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
